// File: rtl/fft_pkg.sv
// Shared FFT sequencer definitions: default size, FSM state encoding and
// the bit-reverse helper used for bit-reversed input loading.
package fft_pkg;

   localparam int FFT_LOG2N = 8;
   localparam int FFT_N     = 1 << FFT_LOG2N;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_GAP,
      ST_DRAIN
   } fft_state_e;

   // Reverse the low n bits of v (n <= 16); upper result bits are zero.
   function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
      logic [15:0] r;
      r = {<<{v}};
      return r >> (16 - n);
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly addressing: operand pair and twiddle index for a
// given stage and butterfly number within that stage.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int LOG2N = FFT_LOG2N
) (
   input  logic [2:0]       stage_i,
   input  logic [LOG2N-2:0] b_i,
   output logic [LOG2N-1:0] addr_a_o,
   output logic [LOG2N-1:0] addr_b_o,
   output logic [LOG2N-2:0] tw_o
);

   localparam logic [2:0] SMAX = 3'(LOG2N - 1);

   logic [LOG2N-1:0] bext, half, mask, pos, a;

   // Group base is b with its low 'stage' bits cleared, doubled; pos is the
   // offset inside the group. Twiddle stride shrinks as stages advance.
   always_comb begin
      bext     = {1'b0, b_i};
      half     = LOG2N'(1) << stage_i;
      mask     = half - LOG2N'(1);
      pos      = bext & mask;
      a        = ((bext & ~mask) << 1) | pos;
      addr_a_o = a;
      addr_b_o = a | half;
      tw_o     = (LOG2N-1)'(pos << (SMAX - stage_i));
   end

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT sequencer: loads N samples, issues N/2 butterflies per stage for
// LOG2N stages with a BFLY_LAT idle gap after each, then drains results.
// Define FFT_BITREV_EN to write input samples at bit-reversed addresses.
module fft_seq_ctrl
   import fft_pkg::*;
#(
   parameter int LOG2N    = FFT_LOG2N,
   parameter int BFLY_LAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr,
   output logic             bf_valid,
   output logic [LOG2N-1:0] bf_addr_a,
   output logic [LOG2N-1:0] bf_addr_b,
   output logic [LOG2N-2:0] tw_idx,
   output logic [2:0]       stage,
   output logic             out_valid,
   output logic [LOG2N-1:0] out_addr,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam int               N          = 1 << LOG2N;
   localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
   localparam logic [LOG2N-2:0] B_LAST     = (LOG2N-1)'(N/2 - 1);
   localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);
   localparam logic [7:0]       GAP_LAST   = 8'(BFLY_LAT - 1);

   fft_state_e       state_q;
   logic [LOG2N-1:0] cnt_q, cnt_d;
   logic [LOG2N-2:0] b_q, b_d;
   logic [2:0]       stage_q;
   logic [7:0]       gap_q;
   logic             in_ready_q, bf_valid_q, out_valid_q, busy_q, done_q;
   logic [LOG2N-1:0] gen_a, gen_b;
   logic [LOG2N-2:0] gen_tw;

   // Full-width counters wrap to zero naturally after their last value.
   assign cnt_d = cnt_q + LOG2N'(1);
   assign b_d   = b_q + (LOG2N-1)'(1);

   fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .stage_i  (stage_q),
      .b_i      (b_q),
      .addr_a_o (gen_a),
      .addr_b_o (gen_b),
      .tw_o     (gen_tw)
   );

   // Sequencer FSM; the shared counter serves as load index then drain index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         b_q         <= '0;
         stage_q     <= '0;
         gap_q       <= '0;
         in_ready_q  <= 1'b0;
         bf_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_LOAD;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  stage_q    <= '0;
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  cnt_q <= cnt_d;
                  if (cnt_q == CNT_LAST) begin
                     state_q    <= ST_COMPUTE;
                     in_ready_q <= 1'b0;
                     bf_valid_q <= 1'b1;
                     b_q        <= '0;
                     stage_q    <= '0;
                  end
               end
            end
            ST_COMPUTE: begin
               b_q <= b_d;
               if (b_q == B_LAST) begin
                  state_q    <= ST_GAP;
                  bf_valid_q <= 1'b0;
                  gap_q      <= '0;
               end
            end
            ST_GAP: begin
               gap_q <= gap_q + 8'd1;
               if (gap_q == GAP_LAST) begin
                  if (stage_q == STAGE_LAST) begin
                     state_q     <= ST_DRAIN;
                     out_valid_q <= 1'b1;
                     cnt_q       <= '0;
                  end else begin
                     state_q    <= ST_COMPUTE;
                     stage_q    <= stage_q + 3'd1;
                     bf_valid_q <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_ready && out_valid_q) begin
                  cnt_q <= cnt_d;
                  if (cnt_q == CNT_LAST) begin
                     state_q     <= ST_IDLE;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign wr_en     = in_valid & in_ready_q;
`ifdef FFT_BITREV_EN
   assign wr_addr   = LOG2N'(bitrev(16'(cnt_q), LOG2N));
`else
   assign wr_addr   = cnt_q;
`endif
   // Butterfly and drain addresses read as zero whenever they are not valid.
   assign bf_valid  = bf_valid_q;
   assign bf_addr_a = bf_valid_q ? gen_a  : '0;
   assign bf_addr_b = bf_valid_q ? gen_b  : '0;
   assign tw_idx    = bf_valid_q ? gen_tw : '0;
   assign stage     = stage_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_valid_q ? cnt_q : '0;
   assign out_last  = out_valid_q && (cnt_q == CNT_LAST);
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed-plus-random bench for fft_seq_ctrl against an arithmetic model
// of load order, butterfly schedule/addressing and drain handshake.
module tb_fft_seq_ctrl;

   localparam int LOG2N  = 8;
   localparam int N      = 1 << LOG2N;
   localparam int HALF_N = N / 2;
   localparam int BL     = 3;
   localparam int PERIOD = HALF_N + BL;

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic             in_valid = 1'b0, out_ready = 1'b0;
   logic             in_ready, wr_en, bf_valid, out_valid, out_last, busy, done;
   logic [LOG2N-1:0] wr_addr, bf_addr_a, bf_addr_b, out_addr;
   logic [LOG2N-2:0] tw_idx;
   logic [2:0]       stage;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fft_seq_ctrl #(.LOG2N(LOG2N), .BFLY_LAT(BL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
      .tw_idx(tw_idx), .stage(stage), .out_valid(out_valid),
      .out_addr(out_addr), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   // Expected write address of the k-th accepted sample.
   function automatic int ref_wr(input int k);
      int r;
      r = k;
`ifdef FFT_BITREV_EN
      r = 0;
      for (int i = 0; i < LOG2N; i++)
         if (((k >> i) & 1) == 1) r = r | (1 << (LOG2N - 1 - i));
`endif
      return r;
   endfunction

   function automatic int ref_a(input int s, input int b);
      int h;
      h = 2 ** s;
      return (b / h) * 2 * h + (b % h);
   endfunction

   function automatic int ref_tw(input int s, input int b);
      return (b % (2 ** s)) * (2 ** (LOG2N - 1 - s));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_stage"},     32'(stage),     0);
      check({tag, "_wr_addr"},   32'(wr_addr),   0);
      check({tag, "_bf_a"},      32'(bf_addr_a), 0);
      check({tag, "_bf_b"},      32'(bf_addr_b), 0);
      check({tag, "_tw"},        32'(tw_idx),    0);
      check({tag, "_out_addr"},  32'(out_addr),  0);
      check({tag, "_in_ready"},  32'(in_ready),  0);
      check({tag, "_wr_en"},     32'(wr_en),     0);
      check({tag, "_bf_valid"},  32'(bf_valid),  0);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_last"},  32'(out_last),  0);
      check({tag, "_busy"},      32'(busy),      0);
      check({tag, "_done"},      32'(done),      0);
   endtask

   initial begin
      int acc, cyc, s, r, k, held;
      logic rdy;

      // Reset state
      #12;
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", 32'(in_ready), 0);

      // Start -> LOAD
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load_in_ready", 32'(in_ready), 1);
      check("load_busy", 32'(busy), 1);

      // LOAD with random in_valid gaps
      acc = 0;
      cyc = 0;
      while (acc < N) begin
         if (cyc > 4000) begin
            check("load_timeout", 32'(acc), 32'(N));
            finish_run();
         end
         in_valid = (($urandom % 4) != 0);
         #1;
         check("load_rdy", 32'(in_ready), 1);
         check("load_wr_en", 32'(wr_en), 32'(in_valid));
         if (in_valid) check("load_wr_addr", 32'(wr_addr), 32'(ref_wr(acc)));
         tick();
         if (in_valid) acc++;
         cyc++;
      end
      in_valid = 1'b0;

      // COMPUTE/GAP schedule with stray start pulses
      for (int t = 0; t < LOG2N * PERIOD; t++) begin
         start = (($urandom % 8) == 0);
         #1;
         s = t / PERIOD;
         r = t % PERIOD;
         check("cmp_bf_valid", 32'(bf_valid), 32'(r < HALF_N));
         check("cmp_stage", 32'(stage), 32'(s));
         check("cmp_in_ready", 32'(in_ready), 0);
         check("cmp_out_valid", 32'(out_valid), 0);
         if (r < HALF_N) begin
            check("cmp_addr_a", 32'(bf_addr_a), 32'(ref_a(s, r)));
            check("cmp_addr_b", 32'(bf_addr_b), 32'(ref_a(s, r) + 2 ** s));
            check("cmp_tw", 32'(tw_idx), 32'(ref_tw(s, r)));
         end
         tick();
      end
      start = 1'b0;

      // DRAIN with random backpressure and a forced 5-cycle stall at 17
      k = 0;
      held = 0;
      cyc = 0;
      forever begin
         if (cyc > 4000) begin
            check("drain_timeout", 32'(k), 32'(N - 1));
            finish_run();
         end
         check("drn_out_valid", 32'(out_valid), 1);
         check("drn_out_addr", 32'(out_addr), 32'(k));
         check("drn_out_last", 32'(out_last), 32'(k == N - 1));
         check("drn_done", 32'(done), 0);
         check("drn_busy", 32'(busy), 1);
         if (k == 17 && held < 5) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = (($urandom % 4) != 0);
         end
         rdy = out_ready;
         tick();
         cyc++;
         if (rdy) begin
            if (k == N - 1) break;
            k++;
         end
      end
      out_ready = 1'b0;
      check("stall_seen", 32'(held), 5);
      check("end_done", 32'(done), 1);
      check("end_busy", 32'(busy), 0);
      check("end_out_valid", 32'(out_valid), 0);
      tick();
      check("done_pulse", 32'(done), 0);

      // Second transform, reset asynchronously during stage 4
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      repeat (N) tick();
      in_valid = 1'b0;
      repeat (4 * PERIOD + 10) tick();
      #1;
      check("mid_stage", 32'(stage), 4);
      check("mid_bf_valid", 32'(bf_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      check_reset_vals("arst");
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_in_ready", 32'(in_ready), 1);
      check("restart_stage", 32'(stage), 0);
      in_valid = 1'b1;
      #1;
      check("restart_wr_en", 32'(wr_en), 1);
      check("restart_wr_addr0", 32'(wr_addr), 32'(ref_wr(0)));
      tick();
      check("restart_wr_addr1", 32'(wr_addr), 32'(ref_wr(1)));
      in_valid = 1'b0;

      finish_run();
   end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameter LOG2N, default 8: log2 of FFT points (N=256); all widths derive from it.
REQ-002 Parameter BFLY_LAT, default 3: butterfly datapath latency in cycles; sets the inter-stage gap.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin one transform; sampled only in IDLE.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block accepts a sample; high only in LOAD.
REQ-008 wr_en / wr_addr  out  1 / LOG2N  sample-RAM write strobe and address.
REQ-009 bf_valid  out  1  butterfly issue strobe.
REQ-010 bf_addr_a / bf_addr_b  out  LOG2N each  butterfly operand addresses.
REQ-011 tw_idx  out  LOG2N-1  twiddle ROM index.
REQ-012 stage  out  3  current stage, 0..LOG2N-1.
REQ-013 out_valid / out_addr / out_last  out  1 / LOG2N / 1  result read request, address, final flag.
REQ-014 out_ready  in  1  downstream accepts the current result.
REQ-015 busy / done  out  1 / 1  not IDLE / one-cycle completion pulse.

Function
REQ-016 FSM states IDLE, LOAD, COMPUTE, GAP, DRAIN; IDLE->LOAD on start; start is ignored in every other state.
REQ-017 LOAD: wr_en = in_valid & in_ready; the load counter advances on each accepted sample; after sample N-1, LOAD->COMPUTE with stage=0 and butterfly index b=0.
REQ-018 COMPUTE: exactly one butterfly issues per cycle with bf_valid=1 and no stalls, N/2 butterflies per stage.
REQ-019 Addressing for stage s and index b: half=2^s, pos=b mod half, addr_a=(b>>s)*2*half+pos, addr_b=addr_a+half, tw_idx=pos<<(LOG2N-1-s).
REQ-020 After the last butterfly of a stage: COMPUTE->GAP; GAP holds bf_valid=0 for exactly BFLY_LAT cycles, then stage increments and returns to COMPUTE.
REQ-021 After the GAP of stage LOG2N-1, go to DRAIN; there is no stage wrap-around.
REQ-022 DRAIN: out_addr counts 0..N-1; out_valid, out_addr and out_last hold until out_ready is seen with out_valid; out_last=1 only at address N-1.
REQ-023 Final DRAIN handshake: done=1 for one cycle, FSM->IDLE.
REQ-024 Counters are full-width; the load and drain counters wrap to 0 on exit.

Reset
REQ-025 rst_n low, at any time including mid-transform: FSM->IDLE and all counters cleared.
REQ-026 Reset values: stage=0, all addresses=0, in_ready=0, wr_en=0, bf_valid=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-027 Reset leaves no partial transform; a new start restarts from LOAD.

Configuration
REQ-028 Macro FFT_BITREV_EN defined: wr_addr = bit-reverse of the load count.
REQ-029 FFT_BITREV_EN undefined: wr_addr = load count, natural order; the input is then already bit-reversed.

Structure
REQ-030 The shared package fft_pkg holds the state enum, LOG2N/N constants and the bit-reverse function.
REQ-031 Sub-module fft_addr_gen computes the REQ-019 combinational addressing from stage and b.

Verification
REQ-032 Reset, then start, then 256 in_valid cycles: wr_addr sequence 0,128,64,192,... with FFT_BITREV_EN; 0..255 without it.
REQ-033 Stage 0: b=0 gives a=0, b=1, tw=0; b=1 gives a=2, b=3. Stage 7: b=5 gives a=5, b=133, tw=5.
REQ-034 BFLY_LAT=3: exactly 3 bf_valid=0 cycles between stages; total COMPUTE+GAP = 8*(128+3) = 1048 cycles.
REQ-035 out_ready held low 5 cycles at address 17: out_addr stays 17 with out_valid=1; out_last and done occur only at address 255.
REQ-036 rst_n asserted in stage 4, then start: in_ready=1 next cycle, stage=0, wr_addr restarts at 0.
REQ-037 start pulsed during COMPUTE: no effect on stage or b sequence.
